bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 16, max cycles one master may hold the bus; 0 disables the timeout.
REQ-002 Parameter CNT_LEN, 12, width of the hold-cycle counter; TIMEOUT_CYCLES SHALL fit in CNT_LEN bits.
REQ-003 Port clk  input  1  rising-edge system clock.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port m1_request  input  1  master 1 approval_request.
REQ-006 Port m2_request  input  1  master 2 approval_request.
REQ-007 Port m1_done  input  1  master 1 transaction complete (its tx_done or rx_done).
REQ-008 Port m2_done  input  1  master 2 transaction complete.
REQ-009 Port m1_grant  output  1  approval_grant to master 1.
REQ-010 Port m2_grant  output  1  approval_grant to master 2.
REQ-011 Port m1_busy  output  1  busy to master 1: master 2 owns the bus.
REQ-012 Port m2_busy  output  1  busy to master 2: master 1 owns the bus.
REQ-013 Port bus_owner  output  2  mux select for shared bus lines: 00 none, 01 master 1, 10 master 2; 11 never driven.
REQ-014 Port timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 FSM states: IDLE, OWN_M1, OWN_M2, RELEASE; all outputs SHALL be decoded from registered state, with no input-to-output combinational path.
REQ-016 In OWN_M1: m1_grant=1, m2_busy=1, bus_owner=01; in OWN_M2: m2_grant=1, m1_busy=1, bus_owner=10; in IDLE and RELEASE: all grant/busy outputs 0 and bus_owner=00.
REQ-017 IDLE and RELEASE SHALL arbitrate identically: only m1_request -> OWN_M1; only m2_request -> OWN_M2; neither -> IDLE.
REQ-018 When both requests are high in IDLE/RELEASE, the master not recorded in last_owner SHALL win (round-robin).
REQ-019 last_owner SHALL update on every entry to OWN_M1/OWN_M2.
REQ-020 Grant latency: a request sampled high at edge k in IDLE SHALL produce its grant immediately after edge k (one cycle).
REQ-021 OWN_Mx -> RELEASE when mx_done=1, when mx_request=0, or on timeout; otherwise OWN_Mx is held.
REQ-022 RELEASE SHALL last exactly one cycle, so there is at least one cycle with no grant between consecutive owners.
REQ-023 The hold counter SHALL clear to 0 on entry to OWN_Mx and increment each cycle in OWN_Mx, saturating at its maximum.
REQ-024 Timeout SHALL fire when TIMEOUT_CYCLES != 0, counter == TIMEOUT_CYCLES-1, and mx_done=0; grant is then held exactly TIMEOUT_CYCLES cycles.
REQ-025 timeout_err SHALL be high for exactly the RELEASE cycle that follows a timeout exit, and 0 otherwise.
REQ-026 If mx_done and the timeout condition coincide, the exit SHALL be treated as a normal exit with timeout_err=0.
REQ-027 The done input of the non-owning master SHALL be ignored.
REQ-028 A request held high through RELEASE by the previous owner SHALL lose to a pending request from the other master, per REQ-018.

Reset
REQ-029 While reset=0: state=IDLE, last_owner=master 2 (so master 1 wins the first tie), counter=0, all outputs 0, asynchronously.
REQ-030 Reset asserted mid-ownership SHALL drop the grant at once; no timeout_err SHALL be generated, and arbitration restarts from IDLE after release.

Verification
REQ-031 Reset release; m1_request=1 at edge 1 -> m1_grant=1, m2_busy=1, bus_owner=01 after edge 1; m1_done pulse at edge 5 -> RELEASE for 1 cycle, then IDLE.
REQ-032 m1_request and m2_request both high from IDLE after reset -> M1 granted first; M1 done -> RELEASE -> OWN_M2 (m2_grant=1, m1_busy=1, bus_owner=10).
REQ-033 TIMEOUT_CYCLES=16, M2 holds request with no done -> m2_grant high exactly 16 cycles, then timeout_err=1 for 1 cycle, bus_owner=00.
REQ-034 m1_done and timeout on the same edge -> RELEASE with timeout_err=0; m2_done pulsed while M1 owns -> no state change.
REQ-035 reset driven low 3 cycles into OWN_M1 -> m1_grant=0 asynchronously; after release with both requests high -> M1 granted.
REQ-036 TIMEOUT_CYCLES=0, M1 holds for 5000 cycles -> grant is never revoked and timeout_err stays 0.

Source files
------------

// File: rtl/bus_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_if
// Description : Handshake bundle between two bus masters and bus_arbiter.
//               slave  modport - arbiter side (samples requests/done,
//                                drives grants, busy flags, owner select).
//               master modport - master side (drives requests/done,
//                                observes grants, busy flags, owner select).
// Signals     : m1_request/m2_request  approval requests
//               m1_done/m2_done        transaction complete
//               m1_grant/m2_grant      approval grants
//               m1_busy/m2_busy        other master owns the bus
//               bus_owner[1:0]         00 none, 01 master 1, 10 master 2
//               timeout_err            one-cycle pulse on timeout revoke
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if;
  logic       m1_request;
  logic       m2_request;
  logic       m1_done;
  logic       m2_done;
  logic       m1_grant;
  logic       m2_grant;
  logic       m1_busy;
  logic       m2_busy;
  logic [1:0] bus_owner;
  logic       timeout_err;

  modport slave (
    input  m1_request, m2_request, m1_done, m2_done,
    output m1_grant, m2_grant, m1_busy, m2_busy, bus_owner, timeout_err
  );

  modport master (
    output m1_request, m2_request, m1_done, m2_done,
    input  m1_grant, m2_grant, m1_busy, m2_busy, bus_owner, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Two-master round-robin bus arbiter with an optional hold
//               timeout. Every owner change passes through a one-cycle
//               RELEASE gap. All outputs are registered.
// Parameters  : TIMEOUT_CYCLES - max cycles one master may hold the bus
//                                (0 disables the timeout)
//               CNT_LEN        - width of the hold-cycle counter
// Ports       : clk   - rising-edge system clock
//               reset - asynchronous active-low reset
//               bus   - bus_arbiter_if.slave handshake bundle
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_LEN        = 12
) (
  input  logic              clk,
  input  logic              reset,
  bus_arbiter_if.slave      bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_M1  = 2'd1,
    ST_OWN_M2  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic               c_OWNER_M1     = 1'b0;
  localparam logic               c_OWNER_M2     = 1'b1;
  localparam logic [CNT_LEN-1:0] c_CNT_MAX      = '1;
  localparam bit                 c_TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_LEN-1:0] c_TIMEOUT_LAST =
    CNT_LEN'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_last_owner;
  logic [CNT_LEN-1:0]   r_hold_cnt;

  logic                 r_m1_grant;
  logic                 r_m2_grant;
  logic                 r_m1_busy;
  logic                 r_m2_busy;
  logic [1:0]           r_bus_owner;
  logic                 r_timeout_err;

  logic                 w_owner_req;
  logic                 w_owner_done;
  logic                 w_timeout_hit;
  logic                 w_timeout_exit;
  logic                 w_enter_own;
  logic                 w_in_own;

  // Request/done of whichever master currently owns the bus; the other
  // master's done is never looked at.
  always_comb begin
    w_owner_req  = 1'b0;
    w_owner_done = 1'b0;
    case (r_state)
      ST_OWN_M1: begin
        w_owner_req  = bus.m1_request;
        w_owner_done = bus.m1_done;
      end
      ST_OWN_M2: begin
        w_owner_req  = bus.m2_request;
        w_owner_done = bus.m2_done;
      end
      default: ;
    endcase
  end

  // Counter holds the number of completed owned cycles, so reaching
  // TIMEOUT_CYCLES-1 means this is the last allowed cycle of the grant.
  assign w_timeout_hit = c_TIMEOUT_EN && (r_hold_cnt == c_TIMEOUT_LAST);
  assign w_in_own      = (r_state == ST_OWN_M1) || (r_state == ST_OWN_M2);

  always_comb begin
    w_next_state   = r_state;
    w_timeout_exit = 1'b0;
    case (r_state)
      ST_IDLE, ST_RELEASE: begin
        if (bus.m1_request && bus.m2_request) begin
          // Tie: whoever did not own the bus last goes next.
          w_next_state = (r_last_owner == c_OWNER_M2) ? ST_OWN_M1 : ST_OWN_M2;
        end else if (bus.m1_request) begin
          w_next_state = ST_OWN_M1;
        end else if (bus.m2_request) begin
          w_next_state = ST_OWN_M2;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_OWN_M1, ST_OWN_M2: begin
        if (w_owner_done || !w_owner_req || w_timeout_hit) begin
          w_next_state = ST_RELEASE;
        end
        // A done arriving together with the timeout counts as a normal exit.
        w_timeout_exit = w_timeout_hit && !w_owner_done;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_enter_own = !w_in_own &&
                       ((w_next_state == ST_OWN_M1) || (w_next_state == ST_OWN_M2));

  // Outputs are decoded from the next state and registered, so they line up
  // with r_state and carry no combinational path from the inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_last_owner  <= c_OWNER_M2;
      r_hold_cnt    <= '0;
      r_m1_grant    <= 1'b0;
      r_m2_grant    <= 1'b0;
      r_m1_busy     <= 1'b0;
      r_m2_busy     <= 1'b0;
      r_bus_owner   <= 2'b00;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (w_enter_own) begin
        r_hold_cnt   <= '0;
        r_last_owner <= (w_next_state == ST_OWN_M2) ? c_OWNER_M2 : c_OWNER_M1;
      end else if (w_in_own && (r_hold_cnt != c_CNT_MAX)) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end

      r_m1_grant    <= (w_next_state == ST_OWN_M1);
      r_m2_busy     <= (w_next_state == ST_OWN_M1);
      r_m2_grant    <= (w_next_state == ST_OWN_M2);
      r_m1_busy     <= (w_next_state == ST_OWN_M2);
      r_bus_owner   <= {(w_next_state == ST_OWN_M2), (w_next_state == ST_OWN_M1)};
      r_timeout_err <= w_timeout_exit;
    end
  end

  assign bus.m1_grant    = r_m1_grant;
  assign bus.m2_grant    = r_m2_grant;
  assign bus.m1_busy     = r_m1_busy;
  assign bus.m2_busy     = r_m2_busy;
  assign bus.bus_owner   = r_bus_owner;
  assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter. dut_a runs with a
//               16-cycle timeout, dut_b with the timeout disabled. Expected
//               output vectors {m1_grant, m2_grant, m1_busy, m2_busy,
//               bus_owner, timeout_err} are queued as stimulus is applied and
//               popped one time unit after the following clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_arbiter_if ifa ();
  bus_arbiter_if ifb ();

  bus_arbiter #(.TIMEOUT_CYCLES(16), .CNT_LEN(12)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  bus_arbiter #(.TIMEOUT_CYCLES(0), .CNT_LEN(12)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  localparam logic [6:0] E_NONE = 7'b0000000;
  localparam logic [6:0] E_M1   = 7'b1001010;
  localparam logic [6:0] E_M2   = 7'b0110100;
  localparam logic [6:0] E_TERR = 7'b0000001;

  logic [6:0] obs_a;
  logic [6:0] obs_b;
  assign obs_a = {ifa.m1_grant, ifa.m2_grant, ifa.m1_busy, ifa.m2_busy,
                  ifa.bus_owner, ifa.timeout_err};
  assign obs_b = {ifb.m1_grant, ifb.m2_grant, ifb.m1_busy, ifb.m2_busy,
                  ifb.bus_owner, ifb.timeout_err};

  logic [6:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus order: {m1_request, m2_request, m1_done, m2_done}
  task automatic drive_a(input logic [3:0] s);
    {ifa.m1_request, ifa.m2_request, ifa.m1_done, ifa.m2_done} = s;
  endtask

  task automatic drive_b(input logic [3:0] s);
    {ifb.m1_request, ifb.m2_request, ifb.m1_done, ifb.m2_done} = s;
  endtask

  task automatic test_reset();
    logic [6:0] want;
    reset = 1'b0;
    drive_a(4'b1100);
    drive_b(4'b1100);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(E_NONE);
      exp_q.push_back(E_NONE);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs_a !== want) $display("FAIL reset_a cyc%0d: got %b expected %b", i, obs_a, want);
      else n_pass++;
      want = exp_q.pop_front();
      n_checks++;
      if (obs_b !== want) $display("FAIL reset_b cyc%0d: got %b expected %b", i, obs_b, want);
      else n_pass++;
    end
    drive_a(4'b0000);
    drive_b(4'b0000);
    reset = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_single_m1();
    logic [3:0] stim [7];
    logic [6:0] expv [7];
    logic [6:0] want;
    stim = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1010, 4'b0000, 4'b0000};
    expv = '{E_M1, E_M1, E_M1, E_M1, E_NONE, E_NONE, E_NONE};
    for (int i = 0; i < 7; i++) begin
      drive_a(stim[i]);
      exp_q.push_back(expv[i]);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs_a !== want) $display("FAIL single_m1 step%0d: got %b expected %b", i, obs_a, want);
      else n_pass++;
    end
  endtask

  // Tie after reset goes to M1; M1 keeps requesting through RELEASE but M2 wins.
  task automatic test_tie();
    logic [3:0] stim [9];
    logic [6:0] expv [9];
    logic [6:0] want;
    stim = '{4'b1100, 4'b1100, 4'b1110, 4'b1100, 4'b1100,
             4'b1000, 4'b1000, 4'b0000, 4'b0000};
    expv = '{E_M1, E_M1, E_NONE, E_M2, E_M2, E_NONE, E_M1, E_NONE, E_NONE};
    for (int i = 0; i < 9; i++) begin
      drive_a(stim[i]);
      exp_q.push_back(expv[i]);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs_a !== want) $display("FAIL tie step%0d: got %b expected %b", i, obs_a, want);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    logic [3:0] s;
    logic [6:0] want;
    for (int i = 0; i < 20; i++) begin
      if (i < 16)       begin s = 4'b0100; exp_q.push_back(E_M2);   end
      else if (i == 16) begin s = 4'b0100; exp_q.push_back(E_TERR); end
      else if (i == 17) begin s = 4'b0100; exp_q.push_back(E_M2);   end
      else              begin s = 4'b0000; exp_q.push_back(E_NONE); end
      drive_a(s);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs_a !== want) $display("FAIL timeout step%0d: got %b expected %b", i, obs_a, want);
      else n_pass++;
    end
  endtask

  // Done coinciding with the timeout is a clean exit; m2_done is ignored
  // while M1 owns; a second full hold by M1 then times out.
  task automatic test_done_timeout();
    logic [3:0] s;
    logic [6:0] want;
    for (int i = 0; i < 36; i++) begin
      if (i < 16) begin
        s = {3'b100, (i == 2 || i == 3)};
        exp_q.push_back(E_M1);
      end else if (i == 16) begin
        s = 4'b1010; exp_q.push_back(E_NONE);
      end else if (i < 33) begin
        s = 4'b1000; exp_q.push_back(E_M1);
      end else if (i == 33) begin
        s = 4'b1000; exp_q.push_back(E_TERR);
      end else begin
        s = 4'b0000; exp_q.push_back(E_NONE);
      end
      drive_a(s);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs_a !== want) $display("FAIL done_timeout step%0d: got %b expected %b", i, obs_a, want);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] stim [5];
    logic [6:0] expv [5];
    logic [6:0] want;
    for (int i = 0; i < 3; i++) begin
      drive_a(4'b1000);
      exp_q.push_back(E_M1);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs_a !== want) $display("FAIL reset_mid own%0d: got %b expected %b", i, obs_a, want);
      else n_pass++;
    end
    // Grant must drop without waiting for a clock edge.
    reset = 1'b0;
    exp_q.push_back(E_NONE);
    #1;
    want = exp_q.pop_front();
    n_checks++;
    if (obs_a !== want) $display("FAIL reset_mid async: got %b expected %b", obs_a, want);
    else n_pass++;
    drive_a(4'b1100);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(E_NONE);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs_a !== want) $display("FAIL reset_mid held%0d: got %b expected %b", i, obs_a, want);
      else n_pass++;
    end
    reset = 1'b1;
    stim = '{4'b1100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    expv = '{E_M1, E_NONE, E_M2, E_NONE, E_NONE};
    for (int i = 0; i < 5; i++) begin
      drive_a(stim[i]);
      exp_q.push_back(expv[i]);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs_a !== want) $display("FAIL reset_mid after%0d: got %b expected %b", i, obs_a, want);
      else n_pass++;
    end
  endtask

  task automatic test_no_timeout();
    logic [6:0] want;
    for (int i = 0; i < 5002; i++) begin
      if (i < 5000) begin drive_b(4'b1000); exp_q.push_back(E_M1);   end
      else          begin drive_b(4'b0000); exp_q.push_back(E_NONE); end
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs_b !== want) $display("FAIL no_timeout cyc%0d: got %b expected %b", i, obs_b, want);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b0;
    drive_a(4'b0000);
    drive_b(4'b0000);
    test_reset();
    test_single_m1();
    do_reset();
    test_tie();
    test_timeout();
    test_done_timeout();
    test_reset_mid();
    test_no_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
